// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    localparam int unsigned DIV_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider; master drives operands, slave returns results.
interface seq_divider_if
    import seq_div_pkg::*;
#(
    parameter int unsigned n = DIV_N
);
    logic           start;
    logic [2*n-1:0] dividend;
    logic [n-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [n-1:0]   quotient;
    logic [n-1:0]   remainder;
    logic           dbz;
    logic           ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz, ovf
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial remainder
// and subtracts the divisor when it fits.
module div_step
    import seq_div_pkg::*;
#(
    parameter int unsigned n = DIV_N
) (
    input  logic [n-1:0] pr_i,
    input  logic         bit_i,
    input  logic [n-1:0] divisor_i,
    output logic [n-1:0] pr_o,
    output logic         q_o
);

    // n+1 bits so the shifted-out MSB of the remainder takes part in the compare.
    logic [n:0] trial;

    always_comb begin
        trial = {pr_i, bit_i};
        q_o   = (trial >= {1'b0, divisor_i});
        pr_o  = q_o ? n'(trial - {1'b0, divisor_i}) : trial[n-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2n-bit dividend by n-bit divisor, one quotient bit per cycle.
// Define SEQ_DIV_OVF_CHECK_EN to flag and short-circuit quotient overflow.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned n = DIV_N
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);

    localparam int unsigned CW = $clog2(n) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  pr_q, pr_d;
    logic [n-1:0]  lo_q, lo_d;
    logic [n-1:0]  qacc_q, qacc_d;
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [n-1:0]  step_pr;
    logic          step_q;
    logic          ovf_hit;

    div_step #(.n(n)) u_step (
        .pr_i      (pr_q),
        .bit_i     (lo_q[n-1]),
        .divisor_i (dvs_q),
        .pr_o      (step_pr),
        .q_o       (step_q)
    );

`ifdef SEQ_DIV_OVF_CHECK_EN
    assign ovf_hit = (bus.dividend[2*n-1:n] >= bus.divisor);
`else
    assign ovf_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        lo_d    = lo_q;
        qacc_d  = qacc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    cnt_d  = CW'(n);
                    dvs_d  = bus.divisor;
                    pr_d   = bus.dividend[2*n-1:n];
                    lo_d   = bus.dividend[n-1:0];
                    qacc_d = '0;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.dividend[n-1:0];
                    end else if (ovf_hit) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d  = cnt_q - CW'(1);
                pr_d   = step_pr;
                lo_d   = lo_q << 1;
                qacc_d = (qacc_q << 1) | n'(step_q);
                if (cnt_q == CW'(1)) begin
                    quo_d   = qacc_d;
                    rem_d   = step_pr;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            lo_q    <= '0;
            qacc_q  <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            lo_q    <= lo_d;
            qacc_q  <= qacc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
// Honours SEQ_DIV_OVF_CHECK_EN when choosing overflow expectations.
module tb_seq_divider;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   scramble = 1'b0;

    seq_divider_if #(.n(N)) bus ();

    seq_divider #(.n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected results straight from integer division and the flag rules.
    function automatic void model(input logic [2*N-1:0] dd, input logic [N-1:0] ds,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output bit dbz, output bit ovf, output bit short_op,
                                  output bit unspec);
        int unsigned qv;
        dbz = 0; ovf = 0; short_op = 0; unspec = 0; q = '0; r = '0;
        if (ds == 0) begin
            dbz = 1; short_op = 1; q = '1; r = dd[N-1:0];
        end else begin
            qv = int'(dd) / int'(ds);
            if (qv > 255) begin
`ifdef SEQ_DIV_OVF_CHECK_EN
                ovf = 1; short_op = 1; q = '1; r = '0;
`else
                unspec = 1;
`endif
            end else begin
                q = N'(qv);
                r = N'(int'(dd) % int'(ds));
            end
        end
    endfunction

    // Called #1 after the capture edge; counts edges until done, bounded.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (!bus.done && lat < int'(N) + 4) begin
            if (bus.busy) busy_cycles++;
            if (scramble) begin
                bus.dividend = (2*N)'($urandom);
                bus.divisor  = N'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [2*N-1:0] dd,
                                input logic [N-1:0] ds, input int lat, input int bc);
        logic [N-1:0] eq, er;
        bit edbz, eovf, eshort, eunspec;
        model(dd, ds, eq, er, edbz, eovf, eshort, eunspec);
        check_eq({tag, ".done"}, 32'(bus.done), 32'(1));
        check_eq({tag, ".latency"}, 32'(lat), eshort ? 32'(0) : 32'(N));
        check_eq({tag, ".busy_cycles"}, 32'(bc), eshort ? 32'(0) : 32'(N));
        check_eq({tag, ".dbz"}, 32'(bus.dbz), 32'(edbz));
        check_eq({tag, ".ovf"}, 32'(bus.ovf), 32'(eovf));
        if (!eunspec) begin
            check_eq({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
            check_eq({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
        end
    endtask

    task automatic do_op(input string tag, input logic [2*N-1:0] dd, input logic [N-1:0] ds);
        int lat, bc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = ds;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        check_result(tag, dd, ds, lat, bc);
    endtask

    initial begin
        int lat, bc;
        bit seen;
        logic [N-1:0] ds, hi;

        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #12;
        check_eq("reset.busy", 32'(bus.busy), 32'(0));
        check_eq("reset.done", 32'(bus.done), 32'(0));
        check_eq("reset.quotient", 32'(bus.quotient), 32'(0));
        check_eq("reset.remainder", 32'(bus.remainder), 32'(0));
        check_eq("reset.dbz", 32'(bus.dbz), 32'(0));
        check_eq("reset.ovf", 32'(bus.ovf), 32'(0));

        // First start at the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("first_start.busy", 32'(bus.busy), 32'(1));
        wait_done(lat, bc);
        check_result("basic_100_7", 16'd100, 8'd7, lat, bc);

        repeat (3) @(posedge clk);
        #1;
        check_eq("hold.quotient", 32'(bus.quotient), 32'(14));
        check_eq("hold.remainder", 32'(bus.remainder), 32'(2));
        check_eq("hold.done_low", 32'(bus.done), 32'(0));

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                do_op($sformatf("walk_i%0d_j%0d", i, j), (2*N)'(1 << (i + j)), N'(1 << j));
            end
        end

        do_op("max_feff_ff", 16'hFEFF, 8'hFF);
        do_op("dbz_1234", 16'h1234, 8'h00);
        do_op("ovf_0a00_05", 16'h0A00, 8'h05);

        // Start held high with scrambled operands during RUN, then a new op from DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor = 8'd7;
        @(posedge clk);
        #1;
        scramble = 1'b1;
        wait_done(lat, bc);
        scramble = 1'b0;
        check_result("held_start", 16'd100, 8'd7, lat, bc);
        bus.dividend = 16'h0FFF;
        bus.divisor = 8'h20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("b2b.busy", 32'(bus.busy), 32'(1));
        check_eq("b2b.done", 32'(bus.done), 32'(0));
        wait_done(lat, bc);
        check_result("b2b", 16'h0FFF, 8'h20, lat, bc);

        // Reset asserted in the fourth RUN cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd12345;
        bus.divisor = 8'd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst.busy", 32'(bus.busy), 32'(0));
        check_eq("midrun_rst.done", 32'(bus.done), 32'(0));
        check_eq("midrun_rst.quotient", 32'(bus.quotient), 32'(0));
        check_eq("midrun_rst.remainder", 32'(bus.remainder), 32'(0));
        check_eq("midrun_rst.dbz", 32'(bus.dbz), 32'(0));
        check_eq("midrun_rst.ovf", 32'(bus.ovf), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (N + 4) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check_eq("midrun_rst.no_done", 32'(seen), 32'(0));

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                ds = '0;
                hi = N'($urandom);
`ifdef SEQ_DIV_OVF_CHECK_EN
            end else if ($urandom_range(0, 7) == 0) begin
                ds = N'($urandom_range(1, 255));
                hi = N'($urandom_range(int'(ds), 255));
`endif
            end else begin
                ds = N'($urandom_range(1, 255));
                hi = N'($urandom_range(0, int'(ds) - 1));
            end
            do_op($sformatf("rand%0d", k), {hi, N'($urandom)}, ds);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
